// File: rtl/hog_axil_pkg.sv
// Shared constants, state types and byte-strobe helper for the HOG AXI4-Lite control slave.
package hog_axil_pkg;

  localparam logic [4:0] ADDR_CTRL       = 5'h00;
  localparam logic [4:0] ADDR_STATUS     = 5'h04;
  localparam logic [4:0] ADDR_IMG_WIDTH  = 5'h08;
  localparam logic [4:0] ADDR_IMG_HEIGHT = 5'h0C;
  localparam logic [4:0] ADDR_SRC_ADDR   = 5'h10;
  localparam logic [4:0] ADDR_DST_ADDR   = 5'h14;
  localparam logic [4:0] ADDR_IRQ_EN     = 5'h18;
  localparam logic [4:0] ADDR_VERSION    = 5'h1C;

  localparam int START_BIT  = 0;
  localparam int READY_BIT  = 0;
  localparam int DONE_BIT   = 1;
  localparam int IRQ_EN_BIT = 0;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} write_state_t;
  typedef enum logic {R_IDLE, R_DATA} read_state_t;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] mergeStrb(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? newVal[8*b +: 8] : oldVal[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hog_axil_slave.sv
// AXI4-Lite control slave for the HOG core: eight word registers, start pulse,
// sticky DONE with W1C, level interrupt and independent read/write channels.
module hog_axil_slave
  import hog_axil_pkg::*;
#(
  parameter int          C_S_AXI_GP_DATA_WIDTH = 32,
  parameter int          C_S_AXI_GP_ADDR_WIDTH = 5,
  parameter logic [31:0] HOG_VERSION           = 32'h0001_0000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                           s_axi_awprot,
  input  logic                                 s_axi_awvalid,
  output logic                                 s_axi_awready,
  input  logic [C_S_AXI_GP_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_GP_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                                 s_axi_wvalid,
  output logic                                 s_axi_wready,
  output logic [1:0]                           s_axi_bresp,
  output logic                                 s_axi_bvalid,
  input  logic                                 s_axi_bready,
  input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                           s_axi_arprot,
  input  logic                                 s_axi_arvalid,
  output logic                                 s_axi_arready,
  output logic [C_S_AXI_GP_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                           s_axi_rresp,
  output logic                                 s_axi_rvalid,
  input  logic                                 s_axi_rready,
  input  logic                                 ready_i,
  input  logic                                 done_i,
  output logic                                 start_o,
  output logic [15:0]                          img_width_o,
  output logic [15:0]                          img_height_o,
  output logic [31:0]                          src_addr_o,
  output logic [31:0]                          dst_addr_o,
  output logic                                 irq_o
);

  write_state_t r_wState, w_wStateNext;
  read_state_t  r_rState, w_rStateNext;

  logic        r_awHeld, r_wHeld;
  logic [2:0]  r_awIdx;
  logic [31:0] r_wData;
  logic [3:0]  r_wStrb;

  logic [15:0] r_imgWidth, r_imgHeight;
  logic [31:0] r_srcAddr, r_dstAddr;
  logic        r_irqEn, r_done, r_start;
  logic [31:0] r_rdata;

  logic        w_bvalid, w_rvalid;
  logic        w_awFire, w_wFire, w_arFire, w_commit;
  logic [2:0]  w_wrIdx;
  logic [31:0] w_wrData, w_oldVal, w_merged;
  logic [3:0]  w_wrStrb;
  logic [31:0] w_regs [8];
  logic        w_unused;

  assign w_bvalid = (r_wState == W_RESP);
  assign w_rvalid = (r_rState == R_DATA);

  assign s_axi_awready = !r_awHeld && !w_bvalid;
  assign s_axi_wready  = !r_wHeld && !w_bvalid;
  assign s_axi_arready = !w_rvalid;

  assign w_awFire = s_axi_awvalid && s_axi_awready;
  assign w_wFire  = s_axi_wvalid && s_axi_wready;
  assign w_arFire = s_axi_arvalid && s_axi_arready;

  // Commit in the cycle the second of AW/W is either already held or arriving.
  assign w_commit = (r_wState == W_IDLE) && (r_awHeld || w_awFire) && (r_wHeld || w_wFire);
  assign w_wrIdx  = r_awHeld ? r_awIdx : s_axi_awaddr[4:2];
  assign w_wrData = r_wHeld ? r_wData : s_axi_wdata;
  assign w_wrStrb = r_wHeld ? r_wStrb : s_axi_wstrb;

  always_comb begin
    w_regs = '{default: '0};
    w_regs[ADDR_STATUS[4:2]][READY_BIT]     = ready_i;
    w_regs[ADDR_STATUS[4:2]][DONE_BIT]      = r_done;
    w_regs[ADDR_IMG_WIDTH[4:2]][15:0]       = r_imgWidth;
    w_regs[ADDR_IMG_HEIGHT[4:2]][15:0]      = r_imgHeight;
    w_regs[ADDR_SRC_ADDR[4:2]]              = r_srcAddr;
    w_regs[ADDR_DST_ADDR[4:2]]              = r_dstAddr;
    w_regs[ADDR_IRQ_EN[4:2]][IRQ_EN_BIT]    = r_irqEn;
    w_regs[ADDR_VERSION[4:2]]               = HOG_VERSION;
  end

  assign w_oldVal = w_regs[w_wrIdx];
  assign w_merged = mergeStrb(w_oldVal, w_wrData, w_wrStrb);

  always_comb begin
    w_wStateNext = r_wState;
    case (r_wState)
      W_IDLE:  if (w_commit)     w_wStateNext = W_RESP;
      W_RESP:  if (s_axi_bready) w_wStateNext = W_IDLE;
      default: w_wStateNext = W_IDLE;
    endcase
  end

  always_comb begin
    w_rStateNext = r_rState;
    case (r_rState)
      R_IDLE:  if (w_arFire)     w_rStateNext = R_DATA;
      R_DATA:  if (s_axi_rready) w_rStateNext = R_IDLE;
      default: w_rStateNext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wState <= W_IDLE;
      r_rState <= R_IDLE;
    end else begin
      r_wState <= w_wStateNext;
      r_rState <= w_rStateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awHeld    <= 1'b0;
      r_wHeld     <= 1'b0;
      r_awIdx     <= '0;
      r_wData     <= '0;
      r_wStrb     <= '0;
      r_imgWidth  <= '0;
      r_imgHeight <= '0;
      r_srcAddr   <= '0;
      r_dstAddr   <= '0;
      r_irqEn     <= 1'b0;
      r_done      <= 1'b0;
      r_start     <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (w_awFire) begin
        r_awHeld <= 1'b1;
        r_awIdx  <= s_axi_awaddr[4:2];
      end
      if (w_wFire) begin
        r_wHeld <= 1'b1;
        r_wData <= s_axi_wdata;
        r_wStrb <= s_axi_wstrb;
      end
      if (w_bvalid && s_axi_bready) begin
        r_awHeld <= 1'b0;
        r_wHeld  <= 1'b0;
      end

      // A start request while the core is busy is dropped, not queued.
      r_start <= w_commit && (w_wrIdx == ADDR_CTRL[4:2]) && w_wrStrb[0]
                 && w_wrData[START_BIT] && ready_i;

      if (w_commit) begin
        case (w_wrIdx)
          ADDR_IMG_WIDTH[4:2]:  r_imgWidth  <= w_merged[15:0];
          ADDR_IMG_HEIGHT[4:2]: r_imgHeight <= w_merged[15:0];
          ADDR_SRC_ADDR[4:2]:   r_srcAddr   <= w_merged;
          ADDR_DST_ADDR[4:2]:   r_dstAddr   <= w_merged;
          ADDR_IRQ_EN[4:2]:     r_irqEn     <= w_merged[IRQ_EN_BIT];
          default: ;
        endcase
      end

      // A completion arriving with the W1C wins so it is never lost.
      if (done_i) begin
        r_done <= 1'b1;
      end else if (w_commit && (w_wrIdx == ADDR_STATUS[4:2]) && w_wrStrb[0]
                   && w_wrData[DONE_BIT]) begin
        r_done <= 1'b0;
      end

      if (w_arFire) begin
        r_rdata <= w_regs[s_axi_araddr[4:2]];
      end
    end
  end

  assign s_axi_bvalid = w_bvalid;
  assign s_axi_bresp  = RESP_OKAY;
  assign s_axi_rvalid = w_rvalid;
  assign s_axi_rresp  = RESP_OKAY;
  assign s_axi_rdata  = r_rdata;
  assign start_o      = r_start;
  assign img_width_o  = r_imgWidth;
  assign img_height_o = r_imgHeight;
  assign src_addr_o   = r_srcAddr;
  assign dst_addr_o   = r_dstAddr;
  assign irq_o        = r_done && r_irqEn;

  assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_hog_axil_slave.sv
// Directed scoreboard bench for hog_axil_slave: B/R responses are queued at issue
// and checked by a separate negedge monitor on each handshake.
module tb_hog_axil_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [4:0]  s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic        ready_i = 1'b1;
  logic        done_i = 1'b0;
  logic        start_o;
  logic [15:0] img_width_o, img_height_o;
  logic [31:0] src_addr_o, dst_addr_o;
  logic        irq_o;

  int nCompared = 0;
  int nMismatched = 0;
  int startCount = 0;
  logic [1:0]  expB [$];
  logic [31:0] expR [$];

  hog_axil_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .ready_i(ready_i), .done_i(done_i), .start_o(start_o),
    .img_width_o(img_width_o), .img_height_o(img_height_o),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every B/R handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_axi_bvalid && s_axi_bready) begin
        if (expB.size() == 0) checkOutput("unexpected_bvalid", 32'd1, 32'd0);
        else checkOutput("bresp", {30'b0, s_axi_bresp}, {30'b0, expB.pop_front()});
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (expR.size() == 0) checkOutput("unexpected_rvalid", 32'd1, 32'd0);
        else checkOutput("rdata", s_axi_rdata, expR.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (start_o) startCount++;
  end

  // One write; wLead > 0 presents W that many cycles before AW.
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int wLead, input logic pulseDone);
    int guard = 0;
    while (!(s_axi_awready && s_axi_wready) && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("wr_idle_ready", {31'b0, s_axi_awready && s_axi_wready}, 32'd1);
    expB.push_back(2'b00);
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    if (wLead > 0) begin
      s_axi_wvalid = 1'b1;
      tick();
      s_axi_wvalid = 1'b0;
      checkOutput("wready_held_low", {31'b0, s_axi_wready}, 32'd0);
      repeat (wLead - 1) begin
        tick();
        checkOutput("no_bvalid_before_aw", {31'b0, s_axi_bvalid}, 32'd0);
      end
    end else begin
      s_axi_wvalid = 1'b1;
    end
    s_axi_awvalid = 1'b1;
    done_i = pulseDone;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    done_i = 1'b0;
    checkOutput("bvalid_latency", {31'b0, s_axi_bvalid}, 32'd1);
    tick();
  endtask

  task automatic readCheck(input logic [4:0] addr, input logic [31:0] expected);
    int guard = 0;
    while (!s_axi_arready && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("rd_idle_ready", {31'b0, s_axi_arready}, 32'd1);
    expR.push_back(expected);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    checkOutput("rvalid_latency", {31'b0, s_axi_rvalid}, 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    repeat (3) tick();
    checkOutput("rst_awready", {31'b0, s_axi_awready}, 32'd1);
    checkOutput("rst_wready",  {31'b0, s_axi_wready},  32'd1);
    checkOutput("rst_arready", {31'b0, s_axi_arready}, 32'd1);
    checkOutput("rst_valids",  {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    checkOutput("rst_outputs", {16'b0, img_width_o} | src_addr_o | dst_addr_o
                               | {31'b0, start_o | irq_o}, 32'd0);
    rst = 1'b0;
    tick();

    readCheck(5'h00, 32'h0000_0000);
    readCheck(5'h1C, 32'h0001_0000);
    readCheck(5'h04, 32'h0000_0001);

    applyStimulus(5'h08, 32'h0000_0280, 4'hF, 0, 1'b0);
    checkOutput("img_width", {16'b0, img_width_o}, 32'h0000_0280);
    readCheck(5'h08, 32'h0000_0280);

    applyStimulus(5'h10, 32'h1234_5678, 4'hF, 3, 1'b0);
    checkOutput("src_addr", src_addr_o, 32'h1234_5678);

    applyStimulus(5'h14, 32'hAABB_CCDD, 4'b0010, 0, 1'b0);
    checkOutput("dst_addr_strb", dst_addr_o, 32'h0000_CC00);
    readCheck(5'h16, 32'h0000_CC00);

    applyStimulus(5'h0C, 32'hFFFF_01E0, 4'b0011, 0, 1'b0);
    checkOutput("img_height", {16'b0, img_height_o}, 32'h0000_01E0);

    s0 = startCount;
    applyStimulus(5'h00, 32'h0000_0001, 4'hF, 0, 1'b0);
    repeat (2) tick();
    checkOutput("start_pulse_count", startCount - s0, 32'd1);
    readCheck(5'h00, 32'h0000_0000);

    ready_i = 1'b0;
    s0 = startCount;
    applyStimulus(5'h00, 32'h0000_0001, 4'hF, 0, 1'b0);
    repeat (2) tick();
    checkOutput("start_dropped_busy", startCount - s0, 32'd0);
    readCheck(5'h04, 32'h0000_0000);
    ready_i = 1'b1;

    applyStimulus(5'h18, 32'h0000_0001, 4'hF, 0, 1'b0);
    checkOutput("irq_before_done", {31'b0, irq_o}, 32'd0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    checkOutput("irq_after_done", {31'b0, irq_o}, 32'd1);
    readCheck(5'h04, 32'h0000_0003);
    applyStimulus(5'h04, 32'h0000_0002, 4'h1, 0, 1'b1);
    checkOutput("done_set_wins", {31'b0, irq_o}, 32'd1);
    readCheck(5'h04, 32'h0000_0003);
    applyStimulus(5'h04, 32'h0000_0002, 4'h1, 0, 1'b0);
    checkOutput("irq_after_w1c", {31'b0, irq_o}, 32'd0);
    readCheck(5'h04, 32'h0000_0001);
    applyStimulus(5'h1C, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    readCheck(5'h1C, 32'h0001_0000);

    // Back-pressure both channels, then reset in the middle of the stall.
    s_axi_bready  = 1'b0;
    s_axi_rready  = 1'b0;
    s_axi_awaddr  = 5'h0C;
    s_axi_wdata   = 32'h0000_0055;
    s_axi_wstrb   = 4'hF;
    s_axi_araddr  = 5'h0C;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    checkOutput("stall_img_height", {16'b0, img_height_o}, 32'h0000_0055);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valids", {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'd3);
      checkOutput("stall_rdata_old", s_axi_rdata, 32'h0000_01E0);
      checkOutput("stall_readies", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
      tick();
    end
    rst = 1'b1;
    tick();
    checkOutput("midrst_valids", {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    checkOutput("midrst_readies", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
    checkOutput("midrst_regs", {16'b0, img_height_o} | src_addr_o | {31'b0, irq_o}, 32'd0);
    rst = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    tick();

    readCheck(5'h0C, 32'h0000_0000);
    applyStimulus(5'h08, 32'h0000_0123, 4'hF, 0, 1'b0);
    readCheck(5'h08, 32'h0000_0123);
    repeat (3) tick();

    checkOutput("expB_drained", expB.size(), 32'd0);
    checkOutput("expR_drained", expR.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/hog_axil_slave.md
Name: hog_axil_slave

Overview:
- AXI4-Lite GP slave that terminates the control port driven by the PS or the UVM master agent.
- Decodes eight 32-bit registers: control, status, image geometry, DDR addresses, interrupt enable, version.
- Sits between the GP port and the HOG core. It converts bus writes into a one-cycle start pulse and configuration levels, and returns core status on reads.

Parameters:
- C_S_AXI_GP_DATA_WIDTH, 32, bus data width (only 32 supported)
- C_S_AXI_GP_ADDR_WIDTH, 5, byte address width (8 word registers)
- HOG_VERSION, 32'h0001_0000, constant returned at 0x1C

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axi_awaddr  in  5  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte lane enables
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response, always 2'b00
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  response ready
- s_axi_araddr  in  5  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response, always 2'b00
- s_axi_rvalid  out  1  read valid
- s_axi_rready  in  1  read ready
- ready_i  in  1  core idle, able to accept start
- done_i  in  1  one-cycle core completion pulse
- start_o  out  1  one-cycle start pulse to core
- img_width_o  out  16  IMG_WIDTH register
- img_height_o  out  16  IMG_HEIGHT register
- src_addr_o  out  32  SRC_ADDR register
- dst_addr_o  out  32  DST_ADDR register
- irq_o  out  1  level interrupt = DONE & IRQ_EN

Behaviour:
- Reset: all outputs, registers and holding flags go to 0. Exception: s_axi_awready, s_axi_wready and s_axi_arready are 1 after reset. A reset mid-transaction drops bvalid/rvalid and discards any held AW/W.
- Register map, decoded on addr[4:2], addr[1:0] ignored:
  - 0x00 CTRL: bit0 START, write-1 pulses, reads 0
  - 0x04 STATUS: bit0 READY (RO, live ready_i); bit1 DONE (sticky, W1C)
  - 0x08 IMG_WIDTH [15:0]
  - 0x0C IMG_HEIGHT [15:0]
  - 0x10 SRC_ADDR
  - 0x14 DST_ADDR
  - 0x18 IRQ_EN bit0
  - 0x1C VERSION (RO)
  - Unused bits read 0.
- Write channel:
  - AW and W are accepted independently. awready = !aw_held & !bvalid; wready = !w_held & !bvalid.
  - Address and data are latched into holding registers on their handshakes.
  - Commit happens in the first cycle where both are held or arriving, honoring wstrb per byte.
  - The register updates and bvalid rises on the clock edge after the last of AW/W handshakes: 1-cycle write latency.
  - bvalid holds until bready; the holds then clear and readies reassert next cycle.
  - Writes to RO registers are accepted with OKAY and have no effect.
- START:
  - start_o = 1 for exactly one cycle, on the commit edge, when CTRL is written with wstrb[0]=1, wdata[0]=1 and ready_i=1.
  - If ready_i=0, the write is dropped silently.
- DONE:
  - Set on done_i.
  - Cleared by a STATUS write with wstrb[0]=1 and wdata[1]=1.
  - Set has priority when done_i and W1C coincide.
- Read channel:
  - arready = !rvalid.
  - On AR handshake, rdata is sampled from the current register values and rvalid rises the next cycle.
  - rdata/rvalid hold until rready.
  - A read of STATUS in the same cycle as done_i returns the pre-update DONE.
- Read and write channels are fully independent; simultaneous read and write to the same register returns the old value.
- FSMs:
  - Write side: W_IDLE (collecting AW/W) -> W_RESP (bvalid) -> W_IDLE on bready.
  - Read side: R_IDLE -> R_DATA -> R_IDLE on rready.

Decomposition:
- Package hog_axil_pkg holds:
  - register offset localparams (ADDR_CTRL .. ADDR_VERSION)
  - bit index constants (START_BIT, READY_BIT, DONE_BIT, IRQ_EN_BIT)
  - RESP_OKAY = 2'b00
  - write_state_t and read_state_t enums
- No sub-module. The register file and both channel FSMs stay in one module of about 250 lines.

Test Plan:
- Write 0x0000_0280 to 0x08 with AW and W in the same cycle -> bvalid next cycle, bresp=00; img_width_o=16'h0280; read 0x08 returns 0x0000_0280.
- W presented 3 cycles before AW, for 0x1234_5678 to 0x10 -> wready drops after W accepted; commit one edge after AW; src_addr_o=0x1234_5678; exactly one bvalid.
- wstrb=4'b0010 write of 0xAABB_CCDD to 0x14 holding 0 -> dst_addr_o=0x0000_CC00.
- ready_i=1, write 0x1 to 0x00 -> start_o high exactly one cycle. Repeat with ready_i=0 -> no pulse; bresp still 00.
- IRQ_EN=1, done_i pulse -> STATUS reads 0x2|ready_i and irq_o=1. W1C 0x2 written on the same cycle as a second done_i -> DONE stays 1. A later W1C alone -> irq_o=0.
- Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid and rdata stable, awready/wready/arready low. Assert rst mid-stall -> all valids 0 next cycle; readies 1.
